// File: rtl/ip_pwm_demod.sv
// ip_pwm_demod: recovers a 16-bit level from a 1-bit PWM stream by counting
// high samples over a window of 2^WINDOW_BITS enable ticks.
module ip_pwm_demod #(
  parameter int WINDOW_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pwm_wave,
  output logic [15:0] signal_level,
  output logic        level_valid,
  output logic        pwm_active
);
  localparam int W = WINDOW_BITS;
  localparam logic [W-1:0] TICK_LAST = '1;
  localparam logic [W:0]   CNT_FULL  = {1'b1, {W{1'b0}}};

  logic [1:0]   sync_ff;
  logic         sync_in;
  logic         prev_sample;
  logic         edge_seen;
  logic         smp_edge;
  logic         win_close;
  logic [W-1:0] tick_cnt;
  logic [W:0]   high_cnt;
  logic [W:0]   final_cnt;
  logic [15:0]  lvl_ext;
  logic [15:0]  level_next;

  // Derive the current sample's edge and the window result including it.
  always_comb begin
    sync_in    = sync_ff[1];
    smp_edge   = sync_in ^ prev_sample;
    win_close  = (tick_cnt == TICK_LAST);
    final_cnt  = high_cnt + (W+1)'(sync_in);
    lvl_ext    = '0;
    lvl_ext[W-1:0] = final_cnt[W-1:0];
    // A full window cannot be represented after the shift, so saturate it.
    level_next = (final_cnt == CNT_FULL) ? 16'hFFFF : (lvl_ext << (16 - W));
  end

  // Two-flop synchronizer; runs every clk regardless of enable.
  always_ff @(posedge clk) begin
    if (reset) sync_ff <= '0;
    else       sync_ff <= {sync_ff[0], pwm_wave};
  end

  // Per-tick sampling: window position, high count and edge tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sample <= 1'b0;
      tick_cnt    <= '0;
      high_cnt    <= '0;
      edge_seen   <= 1'b0;
    end else if (enable) begin
      prev_sample <= sync_in;
      tick_cnt    <= tick_cnt + W'(1);
      if (win_close) begin
        high_cnt  <= '0;
        edge_seen <= 1'b0;
      end else begin
        high_cnt  <= final_cnt;
        edge_seen <= edge_seen | smp_edge;
      end
    end
  end

  // Publish the window result with a single-cycle strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      signal_level <= '0;
      level_valid  <= 1'b0;
      pwm_active   <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      if (enable && win_close) begin
        signal_level <= level_next;
        pwm_active   <= edge_seen | smp_edge;
        level_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ip_pwm_demod.sv
// Scoreboard bench for ip_pwm_demod: a window-level reference model predicts
// each level/strobe; a negedge monitor checks every DUT output cycle.
module tb_ip_pwm_demod;
  localparam int W   = 10;
  localparam int WIN = 1 << W;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        pwm_wave = 1'b0;
  logic [15:0] signal_level;
  logic        level_valid;
  logic        pwm_active;

  ip_pwm_demod #(.WINDOW_BITS(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pwm_wave(pwm_wave),
    .signal_level(signal_level), .level_valid(level_valid), .pwm_active(pwm_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] lvl;
    logic        act;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          nvalid = 0;
  logic [15:0] last_level = '0;
  logic        last_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: a sample is the pwm value seen two clk edges earlier;
  // every WIN samples form a window whose duty and edge presence are computed
  // from the stored sample list.
  bit          h0, h1, smp, last_s, ed, p;
  bit          win[$];
  int          cyc = 0;
  int          cnt;
  logic [15:0] exp_level = '0;
  logic        exp_active = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      h0 = 0; h1 = 0; last_s = 0;
      win.delete();
      exp_level = '0; exp_active = 1'b0;
    end else begin
      smp = h1; h1 = h0; h0 = pwm_wave;
      if (enable) begin
        win.push_back(smp);
        if (win.size() == WIN) begin
          cnt = 0; ed = 0; p = last_s;
          foreach (win[i]) begin
            cnt += int'(win[i]);
            if (win[i] != p) ed = 1;
            p = win[i];
          end
          last_s     = p;
          exp_level  = (cnt == WIN) ? 16'hFFFF : 16'(cnt * (65536 / WIN));
          exp_active = ed;
          sb.push_back('{exp_level, exp_active, cyc});
          win.delete();
        end
      end
    end
  end

  // Monitor: strobes must match queued predictions; outputs must hold between.
  always @(negedge clk) begin
    exp_t e;
    if (level_valid) begin
      nvalid++;
      last_level  = signal_level;
      last_active = pwm_active;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(level_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_level", 32'(signal_level), 32'(e.lvl));
        chk("sb_active", 32'(pwm_active), 32'(e.act));
        chk("sb_valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk("missing_valid", 32'(level_valid), 32'd1);
    end
    chk("hold_level", 32'(signal_level), 32'(exp_level));
    chk("hold_active", 32'(pwm_active), 32'(exp_active));
  end

  // One enable tick: pwm set first, enable pulse gap clk later.
  task automatic tick(input bit v, input int gap);
    @(posedge clk); #1;
    pwm_wave = v;
    enable   = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
    enable = 1'b1;
  endtask

  // Let the pending tick be sampled and its strobe reach the monitor.
  task automatic flush();
    @(posedge clk); #1;
    enable = 1'b0;
    #5;
  endtask

  task automatic window_const(input bit v, input int gap);
    for (int i = 0; i < WIN; i++) tick(v, gap);
    flush();
  endtask

  int          base;
  logic [15:0] phase;
  int          prev_lb;

  initial begin
    // Reset held with enable toggling: outputs stay zero.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      enable = ~enable;
      @(negedge clk);
      chk("rst_level", 32'(signal_level), 32'd0);
      chk("rst_valid", 32'(level_valid), 32'd0);
      chk("rst_active", 32'(pwm_active), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0; enable = 1'b0;

    // Window 1 at 8-clk spacing, then two more low windows.
    base = nvalid;
    window_const(1'b0, 8);
    chk("first_window_valids", 32'(nvalid - base), 32'd1);
    for (int k = 0; k < 2; k++) begin
      window_const(1'b0, 3);
      chk("zero_level", 32'(last_level), 32'h0000);
      chk("zero_active", 32'(last_active), 32'd0);
    end

    // Constant high: saturates; edge only seen in the first window.
    for (int k = 0; k < 3; k++) begin
      window_const(1'b1, 3);
      chk("one_level", 32'(last_level), 32'hFFFF);
      chk("one_active", 32'(last_active), (k == 0) ? 32'd1 : 32'd0);
    end

    // 25% duty aligned to the window.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < WIN; i++) tick(i < 256, 3);
      flush();
      chk("q25_level", 32'(last_level), 32'h4000);
      chk("q25_active", 32'(last_active), 32'd1);
    end

    // Odd counts: one high sample, then 1023.
    for (int i = 0; i < WIN; i++) tick(i == 0, 3);
    flush();
    chk("odd1_level", 32'(last_level), 32'h0040);
    for (int i = 0; i < WIN; i++) tick(i != 0, 3);
    flush();
    chk("odd1023_level", 32'(last_level), 32'hFFC0);

    // Random data with random tick spacing.
    for (int i = 0; i < WIN; i++) tick(1'($urandom_range(0, 1)), int'($urandom_range(3, 5)));
    flush();

    // Reset mid-window discards the partial count.
    for (int i = 0; i < 500; i++) tick(i[0], 3);
    @(posedge clk); #1;
    enable = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    base = nvalid;
    for (int i = 0; i < WIN - 1; i++) tick(i < 256, 3);
    @(posedge clk); #6;
    chk("no_early_valid", 32'(nvalid - base), 32'd0);
    tick(1'b0, 3);
    flush();
    chk("post_reset_valids", 32'(nvalid - base), 32'd1);
    chk("post_reset_level", 32'(last_level), 32'h4000);

    // Loopback sweep: a PWM source with a 1024-tick period, enable every clk.
    prev_lb = 0;
    phase   = '0;
    for (int s = 0; s < 16; s++) begin
      for (int i = 0; i < 2 * WIN; i++) begin
        tick(int'(phase) < s * 4096, 1);
        phase = phase + 16'd64;
      end
      flush();
      chk("lb_monotonic", 32'(int'(last_level) >= prev_lb), 32'd1);
      chk("lb_within_tol", 32'((int'(last_level) - s * 4096 <= 128) &&
                               (s * 4096 - int'(last_level) <= 128)), 32'd1);
      prev_lb = int'(last_level);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_pwm_demod.md
# ip_pwm_demod

Recovers a 16-bit signal level from a 1-bit pulse-width-modulated stream, the receive-side counterpart of `ip_pwm`. The block samples the incoming wave on the shared `enable` tick and counts high samples over a fixed window of 2^WINDOW_BITS ticks. At the end of each window it emits the scaled duty cycle as `signal_level` with a one-cycle valid strobe. It is used for PWM loopback checking and for capturing external PWM audio or control lines into the same level format that `ip_pwm` consumes.

## Interface
- WINDOW_BITS, 10, log2 of window length in enable ticks; legal range 1..16.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  sample tick, one clk wide; any spacing ≥1 clk is legal.
- pwm_wave  in  1  PWM input, asynchronous to clk.
- signal_level  out  16  duty cycle of the last completed window; 0x0000 = all low, 0xFFFF = all high.
- level_valid  out  1  one-clk pulse when signal_level is updated.
- pwm_active  out  1  1 if at least one sampled edge occurred in the last completed window.

## Operation
- Input synchronizer: 2-FF chain on pwm_wave, clocked every clk. Its output is `sync_in`.
- Sampling happens only on clk edges where enable=1. On each sample:
  - The sampled value is `sync_in`.
  - edge = sample XOR prev_sample; then prev_sample <= sample.
  - tick_cnt (WINDOW_BITS bits) increments and wraps to 0 after 2^W−1.
  - high_cnt (WINDOW_BITS+1 bits) increments when sample=1.
  - edge_seen is set when edge=1.
- Window close: the sample taken when tick_cnt == 2^W−1. On that edge, the values below include the closing sample:
  - final_cnt = high_cnt + sample, in the range 0..2^W.
  - signal_level <= 16'hFFFF if final_cnt == 2^W; otherwise final_cnt << (16−W), zero-filled.
  - pwm_active <= edge_seen OR edge.
  - level_valid <= 1 for exactly one clk.
  - high_cnt <= 0, edge_seen <= 0, tick_cnt wraps to 0.
- Between window closes, signal_level and pwm_active hold their value and level_valid=0.
- Sampling ignores edges of pwm_wave that occur between enable ticks. No glitch filtering is applied.

## Timing
- Reset values: signal_level=0, level_valid=0, pwm_active=0. Internally: sync FFs=0, prev_sample=0, tick_cnt=0, high_cnt=0, edge_seen=0.
- Reset dominates enable. enable asserted during reset is ignored.
- Reset mid-window discards the partial count. The first level_valid after reset follows exactly 2^W enable ticks counted after reset deassertion.
- Input latency: a pwm_wave change is visible to sampling 2 clk later. A level held ≥2 clk before an enable tick is guaranteed to be sampled.
- Output latency: level_valid and the new signal_level appear together, in the cycle after the clk edge that sampled the closing tick.
- The first sample after reset compares against prev_sample=0. A constantly high input therefore reports pwm_active=1 for window 1 and 0 for every later window.
- enable held high continuously gives 1 sample per clk, which is legal. Window length is then 2^W clk.
- W=16: high_cnt is 17 bits and the shift is 0. An all-high window saturates to 0xFFFF.

## Test plan
- Use WINDOW_BITS=10 and an enable pulse every 8 clk for all scenarios.
- Reset check: hold reset 5 clk with enable toggling.
  - Required: all outputs 0 throughout.
  - Required: first level_valid lands 1 clk after the 1024th post-reset enable.
- Constant input: pwm_wave=0 for 3 windows, then 1 for 3 windows.
  - Required with input 0: signal_level=0x0000, pwm_active=0.
  - Required with input 1: 0xFFFF for all three windows; pwm_active=1, then 0, then 0.
- 25% duty: drive pwm_wave high for 256 of every 1024 ticks, aligned to the window.
  - Required: signal_level=0x4000, pwm_active=1, level_valid exactly 1 clk wide per window.
- Odd count: 1 high sample per window.
  - Required: signal_level=0x0040.
  - Then 1023 high samples. Required: signal_level=0xFFC0.
- Reset mid-window: run 500 ticks at 50% duty, pulse reset 1 clk, then continue at 25% duty.
  - Required: no level_valid before 1024 post-reset ticks; first level reads 0x4000.
- Loopback: connect ip_pwm's pwm_wave to this block's pwm_wave and sweep ip_pwm's signal_level 0..65535 in steps of 4096, holding each step ≥2 windows.
  - Required: the second-window level is monotonic non-decreasing across steps.
  - Required: each level is within ±0x0080 of the sweep value.
